// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues sequential reads to a synchronous instruction
// memory and buffers the responses in a small FIFO ahead of the CPU.
`timescale 1ns/1ps

module ifetch_unit #(
    parameter int PC_W   = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    output logic [PC_W-1:0]   imem_addr,
    output logic              imem_rd,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] instr,
    output logic [PC_W-1:0]   instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              halt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PC_W-1:0]   r_fetch_pc;
    logic [CW-1:0]     r_count;
    logic              r_inflight;
    logic [PC_W-1:0]   r_inflight_pc;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     r_wr_ptr;
    logic [DATA_W-1:0] r_fifo_instr [DEPTH];
    logic [PC_W-1:0]   r_fifo_pc    [DEPTH];

    logic              w_pop;
    logic              w_push;
    logic [CW:0]       w_occ;

    assign w_pop  = instr_valid && instr_ready;
    assign w_push = r_inflight && !redirect;

    // Occupancy after this edge if nothing new were issued; a pop implies count>=1, so no underflow.
    assign w_occ  = (CW+1)'(r_count) + (CW+1)'(r_inflight) - (CW+1)'(w_pop);

    assign imem_rd   = !reset && !halt && !redirect && (w_occ < (CW+1)'(DEPTH));
    assign imem_addr = r_fetch_pc;

    assign instr_valid = (r_count != CW'(0));
    assign instr       = instr_valid ? r_fifo_instr[r_rd_ptr] : {DATA_W{1'b0}};
    assign instr_pc    = instr_valid ? r_fifo_pc[r_rd_ptr]    : {PC_W{1'b0}};

    // Fetch PC, in-flight tracking, FIFO pointers/count and FIFO storage.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= {PC_W{1'b0}};
            r_count       <= CW'(0);
            r_inflight    <= 1'b0;
            r_inflight_pc <= {PC_W{1'b0}};
            r_rd_ptr      <= AW'(0);
            r_wr_ptr      <= AW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_instr[i] <= {DATA_W{1'b0}};
                r_fifo_pc[i]    <= {PC_W{1'b0}};
            end
        end else if (redirect) begin
            // Flush wins over any pop; the stale response is dropped.
            r_fetch_pc <= redirect_pc;
            r_count    <= CW'(0);
            r_inflight <= 1'b0;
            r_rd_ptr   <= AW'(0);
            r_wr_ptr   <= AW'(0);
        end else begin
            if (imem_rd) begin
                r_fetch_pc    <= r_fetch_pc + PC_W'(1);
                r_inflight    <= 1'b1;
                r_inflight_pc <= r_fetch_pc;
            end else if (w_push) begin
                r_inflight <= 1'b0;
            end else begin
                r_inflight <= r_inflight;
            end

            if (w_push) begin
                r_fifo_instr[r_wr_ptr] <= imem_data;
                r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
                r_wr_ptr               <= r_wr_ptr + AW'(1);
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit (PC_W=5, DATA_W=32, DEPTH=2)
// against a synchronous memory returning word[i] = i + 100.
`timescale 1ns/1ps

module tb_ifetch_unit;

    logic        CLOCK_50;
    logic        reset;
    logic [4:0]  imem_addr;
    logic        imem_rd;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [4:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [4:0]  redirect_pc;
    logic        halt;

    int n_cmp;
    int n_err;

    ifetch_unit #(.PC_W(5), .DATA_W(32), .DEPTH(2)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_rd    (imem_rd),
        .imem_data  (imem_data),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Synchronous instruction memory: data valid the cycle after the sampling edge.
    always @(posedge CLOCK_50) begin
        if (imem_rd) imem_data <= {27'd0, imem_addr} + 32'd100;
    end

    // Move to the next cycle window: 2ns after the rising edge.
    task automatic nxt();
        @(posedge CLOCK_50);
        #2;
    endtask

    // Pulse reset for one edge and release it; leaves the bench in cycle 0.
    task automatic start_fresh(input logic rdy);
        nxt();
        reset       = 1'b1;
        halt        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 5'd0;
        instr_ready = rdy;
        nxt();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge CLOCK_50);
        #2;
        if (imem_rd !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'd0 || instr_pc !== 5'd0 || imem_addr !== 5'd0) begin
            n_err++;
            $display("FAIL reset: rd=%b v=%b instr=%0d pc=%0d addr=%0d, want all 0", imem_rd, instr_valid, instr, instr_pc, imem_addr);
        end
        n_cmp++;
    endtask

    task automatic test_stream();
        logic [4:0] ep;
        start_fresh(1'b1);
        #1;
        if (imem_rd !== 1'b1 || imem_addr !== 5'd0 || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stream_c0: rd=%b addr=%0d v=%b, want rd=1 addr=0 v=0", imem_rd, imem_addr, instr_valid);
        end
        n_cmp++;
        nxt(); #1;
        if (imem_rd !== 1'b1 || imem_addr !== 5'd1 || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stream_c1: rd=%b addr=%0d v=%b, want rd=1 addr=1 v=0", imem_rd, imem_addr, instr_valid);
        end
        n_cmp++;
        for (int k = 2; k < 10; k++) begin
            nxt(); #1;
            ep = 5'(k - 2);
            if (instr_valid !== 1'b1 || instr_pc !== ep || instr !== {27'd0, ep} + 32'd100) begin
                n_err++;
                $display("FAIL stream_c%0d: v=%b pc=%0d instr=%0d, want v=1 pc=%0d instr=%0d", k, instr_valid, instr_pc, instr, ep, ep + 100);
            end
            n_cmp++;
        end
    endtask

    task automatic test_backpressure();
        int nreads;
        nreads = 0;
        start_fresh(1'b0);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) nxt();
            #1;
            if (imem_rd === 1'b1) begin
                if (imem_addr !== 5'(nreads)) begin
                    n_err++;
                    $display("FAIL bp_addr: addr=%0d, want %0d", imem_addr, nreads);
                end
                n_cmp++;
                nreads++;
            end
        end
        if (nreads != 2 || instr_valid !== 1'b1 || instr_pc !== 5'd0 || instr !== 32'd100) begin
            n_err++;
            $display("FAIL bp_full: reads=%0d v=%b pc=%0d instr=%0d, want reads=2 v=1 pc=0 instr=100", nreads, instr_valid, instr_pc, instr);
        end
        n_cmp++;
        nxt();
        instr_ready = 1'b1;
        #1;
        if (instr_pc !== 5'd0 || imem_rd !== 1'b1 || imem_addr !== 5'd2) begin
            n_err++;
            $display("FAIL bp_release: pc=%0d rd=%b addr=%0d, want pc=0 rd=1 addr=2", instr_pc, imem_rd, imem_addr);
        end
        n_cmp++;
        for (int k = 1; k < 5; k++) begin
            nxt(); #1;
            if (instr_valid !== 1'b1 || instr_pc !== 5'(k) || instr !== 32'(k + 100)) begin
                n_err++;
                $display("FAIL bp_drain%0d: v=%b pc=%0d instr=%0d, want v=1 pc=%0d instr=%0d", k, instr_valid, instr_pc, instr, k, k + 100);
            end
            n_cmp++;
        end
    endtask

    task automatic test_redirect();
        start_fresh(1'b1);
        #1;
        nxt(); #1;
        nxt();
        redirect    = 1'b1;
        redirect_pc = 5'd20;
        #1;
        if (imem_rd !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 5'd0) begin
            n_err++;
            $display("FAIL redir_cycle: rd=%b v=%b pc=%0d, want rd=0 v=1 pc=0", imem_rd, instr_valid, instr_pc);
        end
        n_cmp++;
        nxt();
        redirect = 1'b0;
        #1;
        if (instr_valid !== 1'b0 || imem_addr !== 5'd20 || imem_rd !== 1'b1) begin
            n_err++;
            $display("FAIL redir_after: v=%b addr=%0d rd=%b, want v=0 addr=20 rd=1", instr_valid, imem_addr, imem_rd);
        end
        n_cmp++;
        nxt(); #1;
        if (instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL redir_stale: v=%b pc=%0d, want v=0", instr_valid, instr_pc);
        end
        n_cmp++;
        for (int k = 0; k < 4; k++) begin
            nxt(); #1;
            if (instr_valid !== 1'b1 || instr_pc !== 5'(20 + k) || instr !== 32'(120 + k)) begin
                n_err++;
                $display("FAIL redir_seq%0d: v=%b pc=%0d instr=%0d, want v=1 pc=%0d instr=%0d", k, instr_valid, instr_pc, instr, 20 + k, 120 + k);
            end
            n_cmp++;
        end
    endtask

    task automatic test_wrap();
        logic [4:0] ep;
        start_fresh(1'b1);
        redirect    = 1'b1;
        redirect_pc = 5'd30;
        #1;
        if (imem_rd !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_redir_rd: rd=%b, want 0", imem_rd);
        end
        n_cmp++;
        nxt();
        redirect = 1'b0;
        #1;
        if (imem_rd !== 1'b1 || imem_addr !== 5'd30) begin
            n_err++;
            $display("FAIL wrap_first_rd: rd=%b addr=%0d, want rd=1 addr=30", imem_rd, imem_addr);
        end
        n_cmp++;
        nxt(); #1;
        ep = 5'd30;
        for (int k = 0; k < 4; k++) begin
            nxt(); #1;
            if (instr_valid !== 1'b1 || instr_pc !== ep || instr !== {27'd0, ep} + 32'd100) begin
                n_err++;
                $display("FAIL wrap_seq%0d: v=%b pc=%0d instr=%0d, want v=1 pc=%0d instr=%0d", k, instr_valid, instr_pc, instr, ep, ep + 100);
            end
            n_cmp++;
            ep = ep + 5'd1;
        end
    endtask

    task automatic test_halt();
        start_fresh(1'b1);
        #1;
        for (int c = 1; c < 4; c++) begin
            nxt(); #1;
        end
        nxt();
        halt = 1'b1;
        #1;
        if (imem_rd !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 5'd2) begin
            n_err++;
            $display("FAIL halt_rise: rd=%b v=%b pc=%0d, want rd=0 v=1 pc=2", imem_rd, instr_valid, instr_pc);
        end
        n_cmp++;
        nxt(); #1;
        if (imem_rd !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 5'd3 || instr !== 32'd103) begin
            n_err++;
            $display("FAIL halt_inflight: rd=%b v=%b pc=%0d instr=%0d, want rd=0 v=1 pc=3 instr=103", imem_rd, instr_valid, instr_pc, instr);
        end
        n_cmp++;
        for (int c = 0; c < 2; c++) begin
            nxt(); #1;
            if (imem_rd !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 5'd4) begin
                n_err++;
                $display("FAIL halt_idle%0d: rd=%b v=%b addr=%0d, want rd=0 v=0 addr=4", c, imem_rd, instr_valid, imem_addr);
            end
            n_cmp++;
        end
        nxt();
        halt = 1'b0;
        #1;
        if (imem_rd !== 1'b1 || imem_addr !== 5'd4) begin
            n_err++;
            $display("FAIL halt_resume: rd=%b addr=%0d, want rd=1 addr=4", imem_rd, imem_addr);
        end
        n_cmp++;
        nxt(); #1;
        nxt(); #1;
        if (instr_valid !== 1'b1 || instr_pc !== 5'd4 || instr !== 32'd104) begin
            n_err++;
            $display("FAIL halt_resume_out: v=%b pc=%0d instr=%0d, want v=1 pc=4 instr=104", instr_valid, instr_pc, instr);
        end
        n_cmp++;
        // Redirect while halted: flush and load the PC, but stay quiet.
        nxt();
        halt        = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 5'd10;
        #1;
        nxt();
        redirect = 1'b0;
        #1;
        for (int c = 0; c < 2; c++) begin
            if (c > 0) begin
                nxt(); #1;
            end
            if (imem_rd !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 5'd10) begin
                n_err++;
                $display("FAIL halt_redir%0d: rd=%b v=%b addr=%0d, want rd=0 v=0 addr=10", c, imem_rd, instr_valid, imem_addr);
            end
            n_cmp++;
        end
        nxt();
        halt = 1'b0;
        #1;
        if (imem_rd !== 1'b1 || imem_addr !== 5'd10) begin
            n_err++;
            $display("FAIL halt_redir_resume: rd=%b addr=%0d, want rd=1 addr=10", imem_rd, imem_addr);
        end
        n_cmp++;
        nxt(); #1;
        nxt(); #1;
        if (instr_valid !== 1'b1 || instr_pc !== 5'd10 || instr !== 32'd110) begin
            n_err++;
            $display("FAIL halt_redir_out: v=%b pc=%0d instr=%0d, want v=1 pc=10 instr=110", instr_valid, instr_pc, instr);
        end
        n_cmp++;
    endtask

    task automatic test_async_reset();
        start_fresh(1'b1);
        #1;
        for (int c = 1; c < 6; c++) begin
            nxt(); #1;
        end
        reset = 1'b1;
        #1;
        if (imem_rd !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'd0 || instr_pc !== 5'd0 || imem_addr !== 5'd0) begin
            n_err++;
            $display("FAIL areset_now: rd=%b v=%b instr=%0d pc=%0d addr=%0d, want all 0", imem_rd, instr_valid, instr, instr_pc, imem_addr);
        end
        n_cmp++;
        #4;
        reset = 1'b0;
        #1;
        if (imem_rd !== 1'b1 || imem_addr !== 5'd0 || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL areset_release: rd=%b addr=%0d v=%b, want rd=1 addr=0 v=0", imem_rd, imem_addr, instr_valid);
        end
        n_cmp++;
        nxt(); #1;
        if (instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL areset_c1: v=%b pc=%0d, want v=0", instr_valid, instr_pc);
        end
        n_cmp++;
        for (int k = 0; k < 3; k++) begin
            nxt(); #1;
            if (instr_valid !== 1'b1 || instr_pc !== 5'(k) || instr !== 32'(100 + k)) begin
                n_err++;
                $display("FAIL areset_seq%0d: v=%b pc=%0d instr=%0d, want v=1 pc=%0d instr=%0d", k, instr_valid, instr_pc, instr, k, 100 + k);
            end
            n_cmp++;
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        reset       = 1'b1;
        halt        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 5'd0;
        instr_ready = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_halt();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
